// File: rtl/text_line_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : text_line_renderer_pkg
//  Purpose  : Shared glyph geometry, display limits and write-queue state
//             encoding for the single-line text renderer.
//  Revision : 1.0  initial release
// ============================================================================
package text_line_renderer_pkg;

    localparam int          GLYPH_W    = 8;
    localparam int          GLYPH_H    = 8;
    localparam logic [7:0]  BLANK_CHAR = 8'h20;
    localparam int          DISP_W     = 640;
    localparam int          DISP_H     = 480;

    // One-entry write queue: either empty or holding a deferred write
    typedef enum logic [0:0] {
        Q_IDLE    = 1'b0,
        Q_PENDING = 1'b1
    } wq_state_t;

endpackage
`default_nettype wire

// File: rtl/text_write_queue.sv
`default_nettype none
// ============================================================================
//  Module   : text_write_queue
//  Purpose  : One-entry pending register for text buffer writes. A write that
//             arrives while the beam is drawing the box is parked here and
//             committed on the first cycle the box is not being drawn, so a
//             line is never rendered with a half-updated buffer.
//  Revision : 1.0  initial release
// ============================================================================
module text_write_queue
    import text_line_renderer_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    input  logic          busy,
    output logic          wr_ready,
    output logic          commit_en,
    output logic [AW-1:0] commit_addr,
    output logic [7:0]    commit_char
);

    wq_state_t     r_state;
    wq_state_t     w_state_next;
    logic          w_latch;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_char;

    // State register; reset discards any pending write
    always_ff @(posedge clk) begin
        if (reset) r_state <= Q_IDLE;
        else       r_state <= w_state_next;
    end

    // Capture the deferred write payload
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_char <= 8'h00;
        end else if (w_latch) begin
            r_addr <= wr_addr;
            r_char <= wr_char;
        end
    end

    // Accept / defer / commit decisions; a direct write bypasses the register
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        wr_ready     = 1'b0;
        commit_en    = 1'b0;
        commit_addr  = wr_addr;
        commit_char  = wr_char;
        case (r_state)
            Q_IDLE: begin
                wr_ready = 1'b1;
                if (wr_en) begin
                    if (busy) begin
                        w_latch      = 1'b1;
                        w_state_next = Q_PENDING;
                    end else begin
                        commit_en    = 1'b1;
                    end
                end
            end
            Q_PENDING: begin
                commit_addr = r_addr;
                commit_char = r_char;
                if (!busy) begin
                    commit_en    = 1'b1;
                    w_state_next = Q_IDLE;
                end
            end
            default: w_state_next = Q_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/text_line_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : text_line_renderer
//  Purpose  : Renders one line of NCHARS 8x8 character cells at a fixed
//             screen position. Two-stage pipeline: stage 1 looks up the cell's
//             character and drives the external font ROM, stage 2 selects the
//             glyph bit. Buffer writes are deferred while the box is visible.
//  Revision : 1.0  initial release
// ============================================================================
module text_line_renderer
    import text_line_renderer_pkg::*;
#(
    parameter int ORIGIN_X = 256,
    parameter int ORIGIN_Y = 232,
    parameter int NCHARS   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                pixel_x,
    input  logic [9:0]                pixel_y,
    input  logic                      video_on,
    input  logic                      wr_en,
    input  logic [$clog2(NCHARS)-1:0] wr_addr,
    input  logic [7:0]                wr_char,
    output logic                      wr_ready,
    output logic [7:0]                rom_char,
    output logic [2:0]                rom_row,
    input  logic [7:0]                rom_data,
    output logic                      pix_on,
    output logic                      pix_valid
);

    localparam int         AW      = $clog2(NCHARS);
    localparam logic [10:0] c_org_x = 11'(ORIGIN_X);
    localparam logic [10:0] c_org_y = 11'(ORIGIN_Y);
    localparam logic [10:0] c_box_w = 11'(GLYPH_W * NCHARS);
    localparam logic [10:0] c_box_h = 11'(GLYPH_H);

    logic [9:0]    w_dx;
    logic [9:0]    w_dy;
    logic          w_in_box;
    logic          w_busy;
    logic [AW-1:0] w_cell;
    logic [2:0]    w_col;
    logic [2:0]    w_row;

    logic          w_commit_en;
    logic [AW-1:0] w_commit_addr;
    logic [7:0]    w_commit_char;

    logic [7:0]    r_buffer [NCHARS];
    logic [2:0]    r_col_d1;
    logic          r_in_box_d1;
    logic          r_video_on_d1;

    // Box-relative offsets; positions left/above the origin wrap to large
    // values, so the explicit lower-bound compare keeps them out of the box
    assign w_dx     = pixel_x - c_org_x[9:0];
    assign w_dy     = pixel_y - c_org_y[9:0];
    assign w_in_box = ({1'b0, pixel_x} >= c_org_x) && ({1'b0, w_dx} < c_box_w) &&
                      ({1'b0, pixel_y} >= c_org_y) && ({1'b0, w_dy} < c_box_h);
    assign w_busy   = w_in_box & video_on;
    assign w_cell   = w_dx[AW+2:3];
    assign w_col    = w_dx[2:0];
    assign w_row    = w_dy[2:0];

    text_write_queue #(
        .AW (AW)
    ) u_wq (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_char     (wr_char),
        .busy        (w_busy),
        .wr_ready    (wr_ready),
        .commit_en   (w_commit_en),
        .commit_addr (w_commit_addr),
        .commit_char (w_commit_char)
    );

    // Text buffer: reset to blanks, written only when the queue commits
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCHARS; i++) r_buffer[i] <= BLANK_CHAR;
        end else if (w_commit_en) begin
            r_buffer[w_commit_addr] <= w_commit_char;
        end
    end

    // Stage 1: character lookup and font ROM address
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_char      <= 8'h00;
            rom_row       <= 3'd0;
            r_col_d1      <= 3'd0;
            r_in_box_d1   <= 1'b0;
            r_video_on_d1 <= 1'b0;
        end else begin
            rom_char      <= w_in_box ? r_buffer[w_cell] : 8'h00;
            rom_row       <= w_in_box ? w_row : 3'd0;
            r_col_d1      <= w_col;
            r_in_box_d1   <= w_busy;
            r_video_on_d1 <= video_on;
        end
    end

    // Stage 2: glyph bit select, bit 7 is the leftmost pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_on    <= 1'b0;
            pix_valid <= 1'b0;
        end else begin
            pix_on    <= r_in_box_d1 & rom_data[3'd7 - r_col_d1];
            pix_valid <= r_video_on_d1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_line_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_text_line_renderer
//  Purpose  : Self-checking bench for text_line_renderer with a small
//             behavioural font ROM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_text_line_renderer;

    localparam int OX = 256;
    localparam int OY = 232;
    localparam int N  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_char;
    logic       wr_ready;
    logic [7:0] rom_char;
    logic [2:0] rom_row;
    logic [7:0] rom_data;
    logic       pix_on;
    logic       pix_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         x;
        int         y;
        logic       v;
        logic [7:0] ec;
        logic [2:0] er;
        logic       ep;
    } vec_t;

    vec_t tbl [14];
    logic vh  [16];

    always #5 clk = ~clk;

    text_line_renderer #(
        .ORIGIN_X (OX),
        .ORIGIN_Y (OY),
        .NCHARS   (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_char   (wr_char),
        .wr_ready  (wr_ready),
        .rom_char  (rom_char),
        .rom_row   (rom_row),
        .rom_data  (rom_data),
        .pix_on    (pix_on),
        .pix_valid (pix_valid)
    );

    // Font: 0x20 blank, 0x01 = 00001100 on every row, 0x00 solid,
    // anything else = code XOR row
    function automatic logic [7:0] font(input logic [7:0] c, input logic [2:0] r);
        if (c == 8'h20)      return 8'h00;
        else if (c == 8'h01) return 8'h0C;
        else if (c == 8'h00) return 8'hFF;
        else                 return c ^ {5'd0, r};
    endfunction

    assign rom_data = font(rom_char, rom_row);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input logic v);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = v;
    endtask

    // Write while the beam is parked outside the box: commits immediately
    task automatic wr_out(input logic [3:0] a, input logic [7:0] c);
        drive(0, 0, 1'b0);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_char = c;
        chk("wr_ready_idle", 32'(wr_ready), 32'd1);
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        wr_addr = 4'd0;
        wr_char = 8'h00;
        drive(0, 0, 1'b0);
        tick();
        tick();
        chk("rst_wr_ready",  32'(wr_ready),  32'd1);
        chk("rst_rom_char",  32'(rom_char),  32'h00);
        chk("rst_rom_row",   32'(rom_row),   32'd0);
        chk("rst_pix_on",    32'(pix_on),    32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        reset = 1'b0;

        // Blank buffer scan across row OY+1
        for (int x = OX; x < OX + 8 * N; x++) begin
            drive(x, OY + 1, 1'b1);
            tick();
            chk("scan_blank_char", 32'(rom_char), 32'h20);
            chk("scan_blank_row",  32'(rom_row),  32'd1);
            if (x > OX) chk("scan_blank_pix", 32'(pix_on), 32'd0);
        end
        drive(0, 0, 1'b0);
        tick();

        // Cell 0 = 0x01, cell 15 = 0x80, then exact 2-cycle latency
        wr_out(4'd0,  8'h01);
        wr_out(4'd15, 8'h80);
        drive(OX + 4, OY + 1, 1'b1);
        tick();
        chk("lat_rom_char", 32'(rom_char), 32'h01);
        chk("lat_rom_row",  32'(rom_row),  32'd1);
        chk("lat_pix_early", 32'(pix_on),  32'd0);
        drive(0, 0, 1'b0);
        tick();
        chk("lat_pix_on",    32'(pix_on),    32'd1);
        chk("lat_pix_valid", 32'(pix_valid), 32'd1);

        // Directed single-pixel vectors (input held two cycles)
        tbl[0]  = '{OX,       OY,     1'b1, 8'h01, 3'd0, 1'b0};
        tbl[1]  = '{OX + 4,   OY + 1, 1'b1, 8'h01, 3'd1, 1'b1};
        tbl[2]  = '{OX + 5,   OY + 7, 1'b1, 8'h01, 3'd7, 1'b1};
        tbl[3]  = '{OX + 6,   OY + 2, 1'b1, 8'h01, 3'd2, 1'b0};
        tbl[4]  = '{OX + 8,   OY + 1, 1'b1, 8'h20, 3'd1, 1'b0};
        tbl[5]  = '{OX + 120, OY,     1'b1, 8'h80, 3'd0, 1'b1};
        tbl[6]  = '{OX + 127, OY + 7, 1'b1, 8'h80, 3'd7, 1'b1};
        tbl[7]  = '{OX + 127, OY,     1'b1, 8'h80, 3'd0, 1'b0};
        tbl[8]  = '{OX + 128, OY,     1'b1, 8'h00, 3'd0, 1'b0};
        tbl[9]  = '{OX - 1,   OY,     1'b1, 8'h00, 3'd0, 1'b0};
        tbl[10] = '{OX + 4,   OY - 1, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[11] = '{OX + 4,   OY + 8, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[12] = '{OX + 4,   OY + 1, 1'b0, 8'h01, 3'd1, 1'b0};
        tbl[13] = '{1023,     1023,   1'b1, 8'h00, 3'd0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].x, tbl[i].y, tbl[i].v);
            tick();
            chk($sformatf("vec%0d_rom_char", i), 32'(rom_char), 32'(tbl[i].ec));
            chk($sformatf("vec%0d_rom_row", i),  32'(rom_row),  32'(tbl[i].er));
            tick();
            chk($sformatf("vec%0d_pix_on", i),    32'(pix_on),    32'(tbl[i].ep));
            chk($sformatf("vec%0d_pix_valid", i), 32'(pix_valid), 32'(tbl[i].v));
        end

        // Deferred write: cell 1 keeps its old value until the box is left
        drive(OX + 10, OY + 3, 1'b1);
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_char = 8'h33;
        chk("defer_ready_before", 32'(wr_ready), 32'd1);
        tick();
        chk("defer_ready_drop", 32'(wr_ready), 32'd0);
        chk("defer_old_cell",   32'(rom_char), 32'h20);
        wr_char = 8'h77;
        for (int x = OX + 11; x < OX + 8 * N; x++) begin
            drive(x, OY + 3, 1'b1);
            tick();
            chk("defer_ready_low", 32'(wr_ready), 32'd0);
            if (x < OX + 16) chk("defer_old_cell", 32'(rom_char), 32'h20);
        end
        drive(OX + 8 * N, OY + 3, 1'b1);
        wr_en = 1'b0;
        chk("defer_ready_commit_cycle", 32'(wr_ready), 32'd0);
        tick();
        chk("defer_ready_back", 32'(wr_ready), 32'd1);
        drive(OX + 8, OY + 3, 1'b1);
        tick();
        chk("defer_new_cell", 32'(rom_char), 32'h33);
        drive(0, 0, 1'b0);
        tick();

        // Reset while a write is pending
        drive(OX + 24, OY, 1'b1);
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_char = 8'h55;
        tick();
        wr_en = 1'b0;
        chk("prst_pending", 32'(wr_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("prst_wr_ready",  32'(wr_ready),  32'd1);
        chk("prst_rom_char",  32'(rom_char),  32'h00);
        chk("prst_pix_on",    32'(pix_on),    32'd0);
        chk("prst_pix_valid0", 32'(pix_valid), 32'd0);
        drive(0, 0, 1'b1);
        tick();
        chk("prst_pix_valid1", 32'(pix_valid), 32'd0);
        drive(OX + 24, OY, 1'b1);
        tick();
        chk("prst_pix_valid2", 32'(pix_valid), 32'd1);
        chk("prst_cell3", 32'(rom_char), 32'h20);
        drive(OX, OY, 1'b1);
        tick();
        chk("prst_cell0", 32'(rom_char), 32'h20);

        // Toggle video_on across two solid cells
        wr_out(4'd0, 8'h00);
        wr_out(4'd1, 8'h00);
        for (int k = 0; k < 16; k++) begin
            vh[k] = (k % 2 == 0);
            drive(OX + k, OY + 2, vh[k]);
            tick();
            if (k >= 1) begin
                chk("tog_pix_valid", 32'(pix_valid), 32'(vh[k-1]));
                chk("tog_pix_on",    32'(pix_on),    32'(vh[k-1]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/text_line_renderer.md
TEXT_LINE_RENDERER -- requirements
Module: text_line_renderer

Interface
REQ-001 Parameter ORIGIN_X, default 256, left pixel column of the text box.
REQ-002 Parameter ORIGIN_Y, default 232, top pixel row of the text box.
REQ-003 Parameter NCHARS, default 16, number of 8x8 character cells in the box (power of two, at most 64).
REQ-004 Port clk, input, 1, the single block clock.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port pixel_x, input, 10, current scan column.
REQ-007 Port pixel_y, input, 10, current scan row.
REQ-008 Port video_on, input, 1, scan position is in the visible area.
REQ-009 Port wr_en, input, 1, a text buffer write is requested this cycle.
REQ-010 Port wr_addr, input, log2(NCHARS), cell index to write.
REQ-011 Port wr_char, input, 8, character code to write.
REQ-012 Port wr_ready, output, 1, the block can accept a write this cycle.
REQ-013 Port rom_char, output, 8, character code driven to the combinational font ROM.
REQ-014 Port rom_row, output, 3, glyph row driven to the font ROM.
REQ-015 Port rom_data, input, 8, font ROM row bits; bit 7 is the leftmost pixel.
REQ-016 Port pix_on, output, 1, text foreground pixel.
REQ-017 Port pix_valid, output, 1, video_on aligned with pix_on.

Function
REQ-018 The block SHALL hold an NCHARS x 8-bit text buffer.
REQ-019 in_box SHALL be true when ORIGIN_X <= pixel_x < ORIGIN_X+8*NCHARS and ORIGIN_Y <= pixel_y < ORIGIN_Y+8.
REQ-020 Offsets dx = pixel_x-ORIGIN_X and dy = pixel_y-ORIGIN_Y SHALL be computed at 10 bits; the cell index is dx[log2(NCHARS)+2:3], the glyph column is dx[2:0], and the glyph row is dy[2:0].
REQ-021 Stage 1 SHALL register the following: rom_char = buffer[cell] when in_box, else 8'h00 with rom_row forced to 0; rom_row = dy[2:0]; glyph column; in_box AND video_on; video_on.
REQ-022 Stage 2 SHALL register pix_on = in_box_d1 AND rom_data[7-col_d1], and pix_valid = video_on_d1.
REQ-023 Latency from pixel_x/pixel_y to pix_on SHALL be exactly 2 cycles; one new pixel SHALL be accepted every cycle.
REQ-024 A write SHALL be accepted on a cycle where wr_en AND wr_ready are both high.
REQ-025 An accepted write SHALL commit to the buffer in the same cycle when the current pixel is not in_box with video_on.
REQ-026 Otherwise the write SHALL be latched in a one-entry pending register, and wr_ready SHALL drop the next cycle.
REQ-027 A pending write SHALL commit on the first cycle that is not (in_box AND video_on); wr_ready SHALL return high the cycle after the commit.
REQ-028 While a write is deferred, a stage 1 read of the same cell SHALL return the old value; the box is never torn mid-line.
REQ-029 A wr_addr >= NCHARS SHALL NOT occur because the width is exact; no wrap logic is needed.
REQ-030 Pixels with pixel_x or pixel_y beyond 639/479 SHALL be treated as not in_box, with no special case.

Reset
REQ-031 On reset, every buffer entry SHALL load 8'h20, which the font ROM renders blank.
REQ-032 On reset, the pending entry SHALL be discarded.
REQ-033 On reset, the outputs SHALL take these values: wr_ready=1, rom_char=0, rom_row=0, pix_on=0, pix_valid=0; both pipeline stages SHALL be cleared.
REQ-034 Reset asserted mid-frame or with a write pending SHALL take effect on the next edge; the pending write is lost.

Structure
REQ-035 The shared package SHALL hold the glyph constants: GLYPH_W=8, GLYPH_H=8, BLANK_CHAR=8'h20, and the display limits 640/480.
REQ-036 One sub-module, text_write_queue (the one-entry pending register plus wr_ready logic), SHALL be instantiated; the font ROM SHALL stay external.

Verification
REQ-037 Scenario: reset, then scan row ORIGIN_Y+1 across the box -> pix_on=0 everywhere and rom_char=8'h20 for every in-box pixel.
REQ-038 Scenario: write cell 0 = 1 while outside the box, then scan (ORIGIN_X+4, ORIGIN_Y+1) -> rom_char=1 and rom_row=1 one cycle later, and pix_on=1 two cycles after the input (row 8'b00001100, column 4).
REQ-039 Scenario: wr_en at pixel (ORIGIN_X+10, ORIGIN_Y+3) with video_on -> wr_ready=0 on the next cycle, the cell keeps its old value through x=ORIGIN_X+8*NCHARS-1, the write commits at the first out-of-box pixel, and wr_ready=1 one cycle later.
REQ-040 Scenario: scan pixel (ORIGIN_X+8*NCHARS, ORIGIN_Y) -> rom_char=0 and pix_on=0; scan (ORIGIN_X-1, ORIGIN_Y) -> the same result.
REQ-041 Scenario: a write is pending, then reset is asserted for 1 cycle -> the cell reads 8'h20, wr_ready=1, and pix_valid=0 for 2 cycles.
REQ-042 Scenario: toggle video_on every cycle in the box -> pix_valid mirrors video_on delayed by exactly 2 cycles, and pix_on=0 whenever pix_valid=0.
